// File: rtl/priority_sensor_interface_mc.sv
// Multi-channel sensor interrupt front end: synchronise, debounce and edge/level-detect N_CH
// sensor lines, latch sticky pending/overrun flags, and present a fixed-priority interrupt.
module priority_sensor_interface_mc #(
    parameter int N_CH    = 8,
    parameter int IDW     = 3,
    parameter int DEB_CYC = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sensor,
    input  logic [N_CH-1:0] mode,
    input  logic [N_CH-1:0] mask,
    input  logic            ack,
    input  logic [IDW-1:0]  ack_id,
    output logic            interrupt,
    output logic [IDW-1:0]  irq_id,
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] overrun
);

    logic [N_CH-1:0] s1_q, s2_q;
    logic [N_CH-1:0] filt_q, filt_d;
    logic [N_CH-1:0] filt_dly_q;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] overrun_q, overrun_d;
    logic            interrupt_q, interrupt_d;
    logic [IDW-1:0]  irq_id_q, irq_id_d;

    logic [N_CH-1:0] evt;
    logic [N_CH-1:0] clr;
    logic [N_CH-1:0] active;
    logic [31:0]     ack_ext;

    generate
        if (DEB_CYC == 0) begin : g_bypass
            assign filt_d = s2_q;
        end else begin : g_deb
            localparam int CW = $clog2(DEB_CYC + 1);
            logic [CW-1:0] cnt_q [N_CH];
            logic [CW-1:0] cnt_d [N_CH];

            // A change is accepted only after DEB_CYC consecutive samples disagree with filt.
            always_comb begin
                // NOTE: every combinational output gets a default first, so no path infers a latch.
                filt_d = filt_q;
                for (int i = 0; i < N_CH; i++) begin
                    cnt_d[i] = '0;
                    if (s2_q[i] != filt_q[i]) begin
                        if (cnt_q[i] == CW'(DEB_CYC - 1)) begin
                            filt_d[i] = s2_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
            end

            // NOTE: this counter array is small control state and must start at zero, so it is
            // reset like ordinary flops rather than treated as an unreset memory.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
                end else begin
                    for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
                end
            end
        end
    endgenerate

    assign ack_ext = 32'(ack_id);
    assign evt     = (mode & filt_q & ~filt_dly_q) | (~mode & filt_q);
    assign active  = pending_q & ~mask;

    always_comb begin
        clr = '0;
        for (int i = 0; i < N_CH; i++) begin
            // Out-of-range ids never match any channel index, so they are ignored.
            clr[i] = ack && (ack_ext == 32'(i));
        end
    end

    // An event beats a simultaneous clear; overrun only tracks edge events on a pending channel.
    assign pending_d   = evt | (pending_q & ~clr);
    assign overrun_d   = (overrun_q | (mode & evt & pending_q)) & ~clr;
    assign interrupt_d = |active;

    always_comb begin
        irq_id_d = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (active[i]) irq_id_d = IDW'(i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            filt_q      <= '0;
            filt_dly_q  <= '0;
            pending_q   <= '0;
            overrun_q   <= '0;
            interrupt_q <= 1'b0;
            irq_id_q    <= '0;
        end else begin
            s1_q        <= sensor;
            s2_q        <= s1_q;
            filt_q      <= filt_d;
            filt_dly_q  <= filt_q;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            interrupt_q <= interrupt_d;
            irq_id_q    <= irq_id_d;
        end
    end

    assign interrupt = interrupt_q;
    assign irq_id    = irq_id_q;
    assign pending   = pending_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_priority_sensor_interface_mc.sv
// Directed bench for priority_sensor_interface_mc: bypass, debounced and 6-channel instances.
module tb_priority_sensor_interface_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sensor, mode, mask;
    logic       ack;
    logic [2:0] ack_id;

    logic       int0, intd, int6;
    logic [2:0] irq0, irqd, irq6;
    logic [7:0] pend0, pendd, ovr0, ovrd;
    logic [5:0] pend6, ovr6;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    priority_sensor_interface_mc #(.N_CH(8), .IDW(3), .DEB_CYC(0)) u_dut0 (
        .clk(clk), .rst(rst), .sensor(sensor), .mode(mode), .mask(mask),
        .ack(ack), .ack_id(ack_id), .interrupt(int0), .irq_id(irq0),
        .pending(pend0), .overrun(ovr0)
    );

    priority_sensor_interface_mc #(.N_CH(8), .IDW(3), .DEB_CYC(4)) u_dut_deb (
        .clk(clk), .rst(rst), .sensor(sensor), .mode(mode), .mask(mask),
        .ack(ack), .ack_id(ack_id), .interrupt(intd), .irq_id(irqd),
        .pending(pendd), .overrun(ovrd)
    );

    priority_sensor_interface_mc #(.N_CH(6), .IDW(3), .DEB_CYC(0)) u_dut6 (
        .clk(clk), .rst(rst), .sensor(sensor[5:0]), .mode(mode[5:0]), .mask(mask[5:0]),
        .ack(ack), .ack_id(ack_id), .interrupt(int6), .irq_id(irq6),
        .pending(pend6), .overrun(ovr6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_one(input logic [2:0] id);
        ack    = 1'b1;
        ack_id = id;
        tick(1);
        ack    = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; sensor = '0; mode = '1; mask = '0; ack = 1'b0; ack_id = '0;
        #12;
        chk("rst_interrupt", 32'(int0), 32'h0);
        chk("rst_irq_id", 32'(irq0), 32'h0);
        chk("rst_pending", 32'(pend0), 32'h0);
        chk("rst_overrun", 32'(ovr0), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // 1: ch3 edge, bypass debounce: pending at E4, interrupt at E5
        sensor[3] = 1'b1;
        tick(4);
        chk("s1_pending_E4", 32'(pend0), 32'h08);
        chk("s1_int_E4", 32'(int0), 32'h0);
        tick(1);
        chk("s1_int_E5", 32'(int0), 32'h1);
        chk("s1_irq_E5", 32'(irq0), 32'h3);
        sensor[3] = 1'b0;
        ack_one(3'd3);
        chk("s1_pending_ack", 32'(pend0), 32'h00);
        tick(1);
        chk("s1_int_ack", 32'(int0), 32'h0);

        // 2: priority, ack and mask
        sensor[2] = 1'b1; sensor[5] = 1'b1;
        tick(5);
        chk("s2_pending", 32'(pend0), 32'h24);
        chk("s2_irq_2", 32'(irq0), 32'h2);
        ack_one(3'd2);
        chk("s2_pending_ack2", 32'(pend0), 32'h20);
        tick(1);
        chk("s2_irq_5", 32'(irq0), 32'h5);
        chk("s2_int_5", 32'(int0), 32'h1);
        mask = 8'h20;
        tick(1);
        chk("s2_int_masked", 32'(int0), 32'h0);
        chk("s2_pending_masked", 32'(pend0), 32'h20);
        mask = 8'h00;
        tick(1);
        chk("s2_int_unmasked", 32'(int0), 32'h1);
        chk("s2_irq_unmasked", 32'(irq0), 32'h5);
        ack_one(3'd5);
        sensor = '0;
        tick(4);
        chk("s2_cleared", 32'(pend0), 32'h00);

        // 4: overrun on ch0
        sensor[0] = 1'b1;
        tick(4);
        chk("s4_pending_first", 32'(pend0), 32'h01);
        chk("s4_ovr_first", 32'(ovr0), 32'h00);
        sensor[0] = 1'b0; tick(3); sensor[0] = 1'b1;
        tick(4);
        chk("s4_ovr_set", 32'(ovr0), 32'h01);
        chk("s4_pending_ovr", 32'(pend0), 32'h01);
        ack_one(3'd0);
        chk("s4_pending_ack", 32'(pend0), 32'h00);
        chk("s4_ovr_ack", 32'(ovr0), 32'h00);
        sensor[0] = 1'b0; tick(3); sensor[0] = 1'b1;
        tick(4);
        chk("s4_pending_again", 32'(pend0), 32'h01);
        chk("s4_ovr_fresh", 32'(ovr0), 32'h00);
        sensor[0] = 1'b0; tick(3); sensor[0] = 1'b1;
        tick(3);
        ack_one(3'd0);
        chk("s4_evt_ack_pending", 32'(pend0), 32'h01);
        chk("s4_evt_ack_ovr", 32'(ovr0), 32'h00);
        ack_one(3'd0);
        sensor[0] = 1'b0;
        tick(4);
        chk("s4_cleanup", 32'(pend0), 32'h00);

        // 5: level mode on ch1
        mode[1] = 1'b0;
        sensor[1] = 1'b1;
        tick(5);
        chk("s5_pending", 32'(pend0), 32'h02);
        chk("s5_irq", 32'(irq0), 32'h1);
        ack_one(3'd1);
        chk("s5_ack_overridden", 32'(pend0), 32'h02);
        tick(1);
        chk("s5_int_held", 32'(int0), 32'h1);
        sensor[1] = 1'b0;
        tick(3);
        ack_one(3'd1);
        chk("s5_ack_after_drop", 32'(pend0), 32'h00);
        tick(1);
        chk("s5_int_clear", 32'(int0), 32'h0);
        chk("s5_level_no_ovr", 32'(ovr0), 32'h00);
        mode[1] = 1'b1;

        // 3: debounce DEB_CYC=4 on ch4
        pulse_reset();
        sensor[4] = 1'b1; tick(3); sensor[4] = 1'b0;
        tick(8);
        chk("s3_glitch_pending", 32'(pendd), 32'h00);
        chk("s3_glitch_int", 32'(intd), 32'h0);
        sensor[4] = 1'b1; tick(4); sensor[4] = 1'b0;
        tick(3);
        chk("s3_int_not_yet", 32'(intd), 32'h0);
        tick(2);
        chk("s3_pending", 32'(pendd), 32'h10);
        chk("s3_int", 32'(intd), 32'h1);
        chk("s3_irq", 32'(irqd), 32'h4);

        // 6: async reset mid-operation, out-of-range ack on 6-channel instance
        pulse_reset();
        sensor = 8'hA5;
        tick(5);
        chk("s6_pending_a5", 32'(pend0), 32'hA5);
        chk("s6_int", 32'(int0), 32'h1);
        chk("s6_irq", 32'(irq0), 32'h0);
        chk("s6_pending6", 32'(pend6), 32'h25);
        #3;
        rst = 1'b0;
        #1;
        chk("s6_rst_pending", 32'(pend0), 32'h00);
        chk("s6_rst_int", 32'(int0), 32'h0);
        chk("s6_rst_irq", 32'(irq0), 32'h0);
        chk("s6_rst_ovr", 32'(ovr0), 32'h00);
        chk("s6_rst_pending6", 32'(pend6), 32'h00);
        tick(1);
        rst = 1'b1;
        tick(4);
        chk("s6_held_high_edge", 32'(pend6), 32'h25);
        tick(1);
        chk("s6_int6", 32'(int6), 32'h1);
        ack_one(3'd7);
        chk("s6_ack7_pending", 32'(pend6), 32'h25);
        chk("s6_ack7_ovr", 32'(ovr6), 32'h00);
        ack_one(3'd6);
        chk("s6_ack6_pending", 32'(pend6), 32'h25);
        chk("s6_ack_int", 32'(int6), 32'h1);
        chk("s6_ack_irq", 32'(irq6), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
